// File: rtl/jpeg_pkg.sv
// Shared types and widths for the JPEG encoder memory path.
// The arbiter uses them to treat both requester ports as an array.
package jpeg_pkg;

  localparam int ADDR_W = 31;
  localparam int DATA_W = 16;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
  } avmm_req_t;

endpackage

// File: rtl/jpeg_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between the pixel fetcher (port 0)
// and the bitstream writer (port 1); commands are forwarded combinationally once granted.
//
//   state | meaning
//   IDLE  | no owner; arbitrate between pending requests, never drive m_* commands
//   GRANT | port gnt owns the master until it goes quiet or HOLD transfers complete
module jpeg_mem_arbiter
  import jpeg_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s0_address,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writedata,
  input  logic [BE_W-1:0]   s0_byteenable,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_waitrequest,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  input  logic [BE_W-1:0]   s1_byteenable,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_waitrequest,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic [BE_W-1:0]   m_byteenable,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_waitrequest,
  output logic              busy,
  output logic              proto_err
);

  localparam int CW = $clog2(HOLD) + 1;

  arb_state_t    state, state_nx;
  logic          gnt, gnt_nx;
  logic          last, last_nx;
  logic [CW-1:0] hold_cnt, hold_nx;
  logic          perr_nx;
  avmm_req_t     req [2];
  avmm_req_t     cur;
  logic [1:0]    wait_out;

  // Only on a tie does history matter: the port that did not own the bus last wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic prev);
    if (r0 && r1) return ~prev;
    return r1;
  endfunction

  assign req[0] = '{s0_address, s0_read, s0_write, s0_writedata, s0_byteenable};
  assign req[1] = '{s1_address, s1_read, s1_write, s1_writedata, s1_byteenable};

  assign s0_waitrequest = wait_out[0];
  assign s1_waitrequest = wait_out[1];
  assign s0_readdata    = m_readdata;
  assign s1_readdata    = m_readdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last      <= 1'b1;
      hold_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      last      <= last_nx;
      hold_cnt  <= hold_nx;
      proto_err <= perr_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    gnt_nx       = gnt;
    last_nx      = last;
    hold_nx      = hold_cnt;
    perr_nx      = proto_err;
    cur          = req[gnt];
    m_address    = '0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_writedata  = '0;
    m_byteenable = '0;
    wait_out     = 2'b11;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        if (req[0].read || req[0].write || req[1].read || req[1].write) begin
          gnt_nx   = rr_pick(req[0].read | req[0].write, req[1].read | req[1].write, last);
          state_nx = GRANT;
          hold_nx  = '0;
        end
      end
      GRANT: begin
        busy          = 1'b1;
        m_address     = cur.address;
        m_writedata   = cur.writedata;
        m_byteenable  = cur.byteenable;
        m_write       = cur.write;
        m_read        = cur.read & ~cur.write;
        wait_out[gnt] = m_waitrequest;
        if (cur.read && cur.write) perr_nx = 1'b1;
        if (!(cur.read || cur.write)) begin
          state_nx = IDLE;
          last_nx  = gnt;
        end else if (!m_waitrequest) begin
          if (hold_cnt == CW'(HOLD - 1)) begin
            state_nx = IDLE;
            last_nx  = gnt;
          end else begin
            hold_nx = hold_cnt + CW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/jpeg_mem_arbiter.md
Name: jpeg_mem_arbiter

Overview:
- Two-requester arbiter that shares the encoder's single 16-bit Avalon-MM master between the source fetcher (port 0, reads YUYV pixels) and the bitstream writer (port 1, writes encoded output).
- Sits between the pipeline's memory clients and the top-level m_* master interface.
- Uses round-robin arbitration with a bounded per-grant hold count and forwards transfers combinationally once granted.

Parameters:
- ADDR_W, 31, word address width (16-bit words)
- DATA_W, 16, data width; BE_W = DATA_W/8
- HOLD, 4, max consecutive completed transfers per grant before forced release (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sN_address  in  ADDR_W  requester N address (N = 0,1; same set per port)
- sN_read  in  1  requester N read request
- sN_write  in  1  requester N write request
- sN_writedata  in  DATA_W  requester N write data
- sN_byteenable  in  BE_W  requester N byte enables
- sN_readdata  out  DATA_W  read data to requester N
- sN_waitrequest  out  1  stall to requester N
- m_address  out  ADDR_W  shared master address
- m_read  out  1  shared master read
- m_write  out  1  shared master write
- m_writedata  out  DATA_W  shared master write data
- m_byteenable  out  BE_W  shared master byte enables
- m_readdata  in  DATA_W  shared master read data
- m_waitrequest  in  1  shared master stall
- busy  out  1  high while in GRANT
- proto_err  out  1  sticky; a granted requester asserted read and write together

Behaviour:
- Requesters obey Avalon rules: they hold address, data and command stable while their waitrequest is high.
- State machine: IDLE, GRANT. Registers: gnt (1 bit), last (1 bit), hold_cnt (clog2(HOLD)+1 bits), proto_err.
- Reset: state=IDLE, last=1 (so port 0 wins the first tie), hold_cnt=0, proto_err=0.
  - All outputs are combinational from state.
  - Result after reset: m_read=m_write=0, sN_waitrequest=1, busy=0.
- IDLE:
  - Request = sN_read|sN_write.
  - Single request: grant that port.
  - Both requesting: grant ~last.
  - Register gnt, go to GRANT, hold_cnt=0.
  - One-cycle arbitration latency; no m_* command is ever driven in IDLE.
- GRANT, forwarding from port gnt:
  - m_address, m_writedata and m_byteenable are forwarded from port gnt.
  - m_write = s_write; m_read = s_read & ~s_write. Write wins a read+write collision, and proto_err is set.
  - s(gnt)_waitrequest = m_waitrequest. The other port's waitrequest = 1.
  - Both sN_readdata = m_readdata; valid only when that port's waitrequest is 0.
  - busy = 1.
- GRANT transitions:
  - Granted port has neither read nor write: release to IDLE, last=gnt, and no command is driven that cycle.
  - Completion (command asserted and m_waitrequest=0) with hold_cnt == HOLD-1: release to IDLE, last=gnt.
  - Completion otherwise: stay in GRANT, hold_cnt+1.
- A released port that wants the bus again competes in IDLE on the next cycle. Minimum one idle bubble between grants.
- Fairness: with both ports continuously requesting, grants alternate every HOLD transfers. With HOLD=1, transfers strictly alternate 0,1,0,1.
- Reset asserted mid-transfer: returns to IDLE next edge; m_read/m_write drop. An in-flight slave access is abandoned; higher levels reset the whole encoder together.
- No internal buffering. Data widths pass through unchanged.

Decomposition:
- Package jpeg_pkg:
  - ADDR_W and DATA_W constants.
  - arb_state_t enum {IDLE, GRANT}.
  - avmm_req_t struct {address, read, write, writedata, byteenable}, so ports can be arrayed internally.
- No sub-module. Round-robin select is a small function in the same file.

Test Plan:
- Reset, then port 0 read at 0x0000010, 3 wait cycles -> m_read high from cycle 2, s0_waitrequest low exactly when m_waitrequest low, s0_readdata = m_readdata, return to IDLE after s0_read drops; s1_waitrequest stays 1 throughout.
- Simultaneous first requests (port 0 read 0x0000000, port 1 write 0x8000000 data 0xABCD be=2'b10) -> port 0 served first. Port 1 write reaches m_* with writedata 0xABCD and byteenable 2'b10 after port 0 releases.
- Both ports continuously requesting, HOLD=4, random 0-9 waitstates -> completions appear in groups 0000 1111 0000...; no command ever in IDLE; no port starved.
- HOLD=1, port 0 alone issuing 8 back-to-back reads -> 8 completions, each followed by one IDLE cycle; addresses forwarded in order.
- Port 1 asserts write and read together (addr 0x8000004) -> m_write=1, m_read=0, proto_err goes 1 and stays 1 until rst.
- rst asserted while GRANT with m_waitrequest=1 -> next cycle IDLE, m_read=m_write=0, busy=0, proto_err=0, sN_waitrequest=1.
